// File: rtl/wordle_pkg.sv
// wordle_pkg -- shared definitions for the Wordle scorer.
//   WORD_LEN / CHAR_W : word geometry (five 8-bit ASCII letters)
//   BLANK             : space character; never matches and never scores
//   color_e           : 2-bit per-letter score codes
//   state_e           : scorer FSM encoding
package wordle_pkg;

  localparam int WORD_LEN = 5;
  localparam int CHAR_W   = 8;

  localparam logic [CHAR_W-1:0] BLANK = 8'h20;

  typedef enum logic [1:0] {
    GREY     = 2'b00,
    YELLOW   = 2'b01,
    GREEN    = 2'b10,
    UNSCORED = 2'b11
  } color_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/wordle_scorer.sv
// wordle_scorer -- scores one Wordle guess against a secret answer.
//
// Ports
//   board_clk : clock, rising edge
//   reset     : asynchronous, active-high
//   start     : score request, sampled only while idle
//   guess     : guessed word, letter 0 in the MSBs
//   answer    : secret word, same letter order
//   busy      : high in every non-idle state
//   done      : one-cycle pulse when colors/win are updated
//   colors    : 2 bits per letter, letter 0 at the MSBs (00 grey,
//               01 yellow, 10 green, 11 unscored)
//   win       : all five letters green
//
// Sequence: IDLE -> GREEN (1 cycle) -> YELLOW (one guess letter per
// cycle) -> DONE (1 cycle, done pulse) -> IDLE.
//
// Build option: define WORDLE_SCORER_DUP_AWARE_EN to make the yellow
// pass consume answer positions (standard duplicate-letter handling).
// Without it, a non-green letter is yellow if it occurs anywhere in the
// answer.
module wordle_scorer
  import wordle_pkg::*;
#(
  parameter int WORD_LEN = 5,
  parameter int CHAR_W   = 8
) (
  input  logic                       board_clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LEN*CHAR_W-1:0] guess,
  input  logic [WORD_LEN*CHAR_W-1:0] answer,
  output logic                       busy,
  output logic                       done,
  output logic [2*WORD_LEN-1:0]      colors,
  output logic                       win
);

  localparam int IDX_W = $clog2(WORD_LEN);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORD_LEN-1);
  localparam logic [2*WORD_LEN-1:0] ALL_GREEN = {WORD_LEN{2'(GREEN)}};

  state_e                      state;
  logic [WORD_LEN*CHAR_W-1:0]  g_q, a_q;     // latched request
  logic [WORD_LEN-1:0]         used;         // answer positions consumed
  logic [IDX_W-1:0]            idx;          // yellow-pass letter index
  logic [2*WORD_LEN-1:0]       res;          // working result

  logic [2*WORD_LEN-1:0]       green_res, yel_res;
  logic [WORD_LEN-1:0]         green_used, yel_used;
  int                          sel;          // letter slot of idx (0 = MSBs side)
  logic [CHAR_W-1:0]           cur_g;
  logic [1:0]                  cur_c;
  logic                        found;

  // Exact-position pass over all letters at once.
  always_comb begin
    green_res  = res;
    green_used = used;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (g_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W] == a_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W] &&
          g_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W] != BLANK) begin
        green_res[(WORD_LEN-1-i)*2 +: 2] = GREEN;
        green_used[i]                    = 1'b1;
      end
    end
  end

  // Yellow pass for the single letter selected by idx.
  assign sel   = WORD_LEN - 1 - int'(idx);
  assign cur_g = g_q[sel*CHAR_W +: CHAR_W];
  assign cur_c = res[sel*2 +: 2];

  always_comb begin
    yel_res  = res;
    yel_used = used;
    found    = 1'b0;
    if (cur_c != GREEN) begin
      if (cur_g != BLANK) begin
        for (int j = 0; j < WORD_LEN; j++) begin
`ifdef WORDLE_SCORER_DUP_AWARE_EN
          // Lowest unused matching position wins; it is then consumed.
          if (!found && !used[j] && a_q[(WORD_LEN-1-j)*CHAR_W +: CHAR_W] == cur_g) begin
            found       = 1'b1;
            yel_used[j] = 1'b1;
          end
`else
          if (a_q[(WORD_LEN-1-j)*CHAR_W +: CHAR_W] == cur_g)
            found = 1'b1;
`endif
        end
      end
      yel_res[sel*2 +: 2] = found ? YELLOW : GREY;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      colors <= '1;
      win    <= 1'b0;
      used   <= '0;
      idx    <= '0;
      res    <= '1;
      g_q    <= '0;
      a_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            g_q   <= guess;
            a_q   <= answer;
            used  <= '0;
            idx   <= '0;
            res   <= '1;
            busy  <= 1'b1;
            state <= ST_GREEN;
          end
        end
        ST_GREEN: begin
          res   <= green_res;
          used  <= green_used;
          state <= ST_YELLOW;
        end
        ST_YELLOW: begin
          res  <= yel_res;
          used <= yel_used;
          if (idx == LAST_IDX) begin
            // Publish on entry to DONE so done/colors/win appear together.
            idx    <= '0;
            colors <= yel_res;
            win    <= (yel_res == ALL_GREEN);
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wordle_scorer.sv
module tb_wordle_scorer;

  logic        board_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [39:0] guess, answer;
  logic        busy, done, win;
  logic [9:0]  colors;

  int          checks   = 0;
  int          failures = 0;
  logic [9:0]  last_colors;

  wordle_scorer #(.WORD_LEN(5), .CHAR_W(8)) dut (
    .board_clk(board_clk), .reset(reset), .start(start),
    .guess(guess), .answer(answer),
    .busy(busy), .done(done), .colors(colors), .win(win)
  );

  always #5 board_clk = ~board_clk;

  typedef struct {
    string       nm;
    logic [39:0] g;
    logic [39:0] a;
    logic [9:0]  c;
    logic        w;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Step to the next cycle; samples are taken 1 time unit after the edge.
  task automatic step();
    @(posedge board_clk);
    #1;
  endtask

  // One scoring run. Cycle 1 is the cycle after the start edge.
  // poke_cyc>0: pulse start with another guess during that cycle.
  task automatic score(input string nm, input logic [39:0] g, input logic [39:0] a,
                       input logic [9:0] ec, input logic ew, input int poke_cyc);
    int ndone, done_cyc, busy_bad, hold_bad;
    ndone = 0; done_cyc = 0; busy_bad = 0; hold_bad = 0;
    guess = g; answer = a; start = 1'b1;
    step();
    start  = 1'b0;
    guess  = "ZZZZZ";   // late input changes must not matter
    answer = "QQQQQ";
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      if (c == poke_cyc) begin start = 1'b1; guess = "WRONG"; answer = "WRONG"; end
      if (c == poke_cyc + 1) start = 1'b0;
      if (done) begin ndone++; done_cyc = c; end
      if ((c <= 7) != busy) busy_bad++;
      if (c < 7 && colors !== last_colors) hold_bad++;
      if (c == 7) begin
        check({nm, " colors"}, colors, ec);
        check({nm, " win"}, win, ew);
      end
    end
    check({nm, " done_count"}, ndone, 1);
    check({nm, " done_cycle"}, done_cyc, 7);
    check({nm, " busy_profile"}, busy_bad, 0);
    check({nm, " colors_hold"}, hold_bad, 0);
    check({nm, " colors_after"}, colors, ec);
    last_colors = ec;
  endtask

  initial begin
    int ndone, d1, d2, bad;
    vecs[0] = '{"crane",  "CRANE", "CRANE", 10'h2AA, 1'b1};
`ifdef WORDLE_SCORER_DUP_AWARE_EN
    vecs[1] = '{"eerie",  "EERIE", "ABBEY", 10'h100, 1'b0};
    vecs[2] = '{"speed",  "EERIE", "SPEED", 10'h140, 1'b0};
    vecs[3] = '{"bbbbb",  "BBBBB", "ABBEY", 10'h0A0, 1'b0};
`else
    vecs[1] = '{"eerie",  "EERIE", "ABBEY", 10'h141, 1'b0};
    vecs[2] = '{"speed",  "EERIE", "SPEED", 10'h141, 1'b0};
    vecs[3] = '{"bbbbb",  "BBBBB", "ABBEY", 10'h1A5, 1'b0};
`endif
    vecs[4] = '{"blank1", "C RAN", "CRANE", 10'b10_00_01_01_01, 1'b0};
    vecs[5] = '{"nacre",  "NACRE", "CRANE", 10'h156, 1'b0};
    vecs[6] = '{"nohit",  "XYZQW", "CRANE", 10'h000, 1'b0};
    vecs[7] = '{"blanks", "     ", "     ", 10'h000, 1'b0};

    reset = 1'b1; start = 1'b0; guess = '0; answer = '0;
    repeat (3) @(posedge board_clk);
    #1;
    check("rst colors", colors, 10'h3FF);
    check("rst win", win, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    reset = 1'b0;
    last_colors = 10'h3FF;
    step();

    foreach (vecs[i]) score(vecs[i].nm, vecs[i].g, vecs[i].a, vecs[i].c, vecs[i].w, 0);

    // Start during busy is ignored: one done, first result.
    score("ignore_start", "CRANE", "CRANE", 10'h2AA, 1'b1, 3);
    check("ignore_start idle", busy, 0);

    // Reset in cycle 4 aborts with no done pulse.
    guess = "NACRE"; answer = "CRANE"; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int c = 2; c <= 4; c++) begin step(); if (done) ndone++; end
    reset = 1'b1;
    #1;
    check("midrst colors", colors, 10'h3FF);
    check("midrst busy", busy, 0);
    check("midrst win", win, 0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin step(); if (done || busy) ndone++; end
    check("midrst no_done", ndone, 0);
    last_colors = 10'h3FF;
    score("after_rst", "C RAN", "CRANE", 10'b10_00_01_01_01, 1'b0, 0);

    // start held high: back-to-back runs with one idle cycle between.
    guess = "CRANE"; answer = "CRANE"; start = 1'b1;
    step();
    ndone = 0; d1 = 0; d2 = 0; bad = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) step();
      if (c == 9) start = 1'b0;
      if (done) begin ndone++; if (d1 == 0) d1 = c; else d2 = c; end
      if (busy != (c != 8 && c != 16)) bad++;
    end
    check("b2b done_count", ndone, 2);
    check("b2b done1", d1, 7);
    check("b2b done2", d2, 15);
    check("b2b busy_profile", bad, 0);
    check("b2b colors", colors, 10'h2AA);
    check("b2b win", win, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net: the sequences above are finite, but never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wordle_scorer.md
WORDLE_SCORER -- requirements
Module: wordle_scorer

Interface
REQ-001 SHALL have parameter WORD_LEN, default 5, letters per word; only 5 is supported.
REQ-002 SHALL have parameter CHAR_W, default 8, bits per ASCII letter.
REQ-003 SHALL have port board_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to score; sampled only in IDLE.
REQ-006 SHALL have port guess  input  40  guessed word; letter 0 (first) = guess[39:32], letter 4 = guess[7:0].
REQ-007 SHALL have port answer  input  40  secret word; same letter ordering as guess.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse when colors and win are updated.
REQ-010 SHALL have port colors  output  10  2 bits per letter, letter 0 at [9:8]: 00 grey, 01 yellow, 10 green, 11 unscored.
REQ-011 SHALL have port win  output  1  high when all five letters scored green.

Function
REQ-012 SHALL implement FSM states IDLE, GREEN, YELLOW, DONE.
REQ-013 In IDLE with start=1, SHALL latch guess and answer, clear five answer-used flags, clear letter index, and enter GREEN.
REQ-014 GREEN (1 cycle) SHALL mark position i green and set used[i] wherever guess letter i == answer letter i and the letter is not blank (8'h20).
REQ-015 YELLOW (exactly 5 cycles, index 0..4) SHALL process one guess letter per cycle; a non-green, non-blank letter takes yellow if some answer position j is unused and matches, setting used[j] for the lowest such j, otherwise grey.
REQ-016 DONE (1 cycle) SHALL drive done=1, load the working result into colors, set win = (all five green), and return to IDLE.
REQ-017 Latency: start sampled on edge 0 -> busy high cycles 1..7 -> done high in cycle 7 -> IDLE in cycle 8.
REQ-018 colors and win SHALL hold their last values from DONE until the next DONE; they SHALL NOT change mid-scoring.
REQ-019 start asserted while busy SHALL be ignored, and no request is queued.
REQ-020 Changes to guess and answer after the start edge SHALL NOT affect the result in progress.
REQ-021 A blank guess letter SHALL score grey and never consume an answer position.
REQ-022 start held high continuously SHALL begin a new scoring on the first IDLE cycle (back-to-back, one IDLE cycle between runs).

Reset
REQ-023 While reset=1: state=IDLE, busy=0, done=0, colors=10'h3FF, win=0, used flags and index cleared.
REQ-024 Reset mid-operation SHALL abort scoring with no done pulse; the first start after reset is accepted normally.

Configuration
REQ-025 With macro WORDLE_SCORER_DUP_AWARE_EN defined, SHALL use the used-flag rules of REQ-014/REQ-015, which handle duplicate letters per standard Wordle.
REQ-026 Without WORDLE_SCORER_DUP_AWARE_EN, a non-green, non-blank letter SHALL be yellow if it appears at any answer position, ignoring used flags; latency and interface are unchanged.

Structure
REQ-027 Package wordle_pkg SHALL hold the color codes (GREY, YELLOW, GREEN, UNSCORED), WORD_LEN, CHAR_W, the BLANK character, and the FSM state encoding.
REQ-028 SHALL be a single module with no sub-module; letter extraction uses indexed part-selects.

Verification
REQ-029 Reset asserted -> colors=10'h3FF, win=0, busy=0, done=0.
REQ-030 answer="CRANE", guess="CRANE", pulse start -> done in cycle 7, colors=10'h2AA, win=1.
REQ-031 answer="ABBEY", guess="EERIE" -> with DUP_AWARE_EN, colors=10'h100; without it, colors=10'h141; win=0 in both cases.
REQ-032 answer="CRANE", guess="C RAN" (blank at letter 1) -> colors=10'b10_00_01_01_01, win=0.
REQ-033 start pulsed again in cycle 3 with a different guess -> ignored; one done only, with the first result.
REQ-034 reset pulsed in cycle 4 of scoring -> no done, colors=10'h3FF; the next start completes normally with done 7 cycles later.
